alarm_mode_controller: RTL
==========================

# alarm_mode_controller

Central control FSM of the alarm clock. It consumes the one-cycle press pulses produced by the five pushbutton detector instances, plus a 1 Hz enable, and maintains the following:
- the running time (hh:mm:ss);
- the alarm time (hh:mm) and the alarm-armed flag;
- the adjust-mode field selection;
- the ring state.

All outputs are registered and feed the display multiplexer and the buzzer driver directly.

## Interface
- RING_SECONDS, 60: number of tick_1hz pulses after which an undismissed alarm stops ringing (1..63).
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- tick_1hz  input  1  one-clk-wide enable, once per second.
- btn_c, btn_u, btn_d, btn_l, btn_r  input  1 each  one-clk-wide press pulses from the pushbutton detectors (center, up, down, left, right).
- hours  output  5  running hours, 0..23.
- minutes  output  6  running minutes, 0..59.
- seconds  output  6  running seconds, 0..59.
- alarm_hours  output  5  alarm hours, 0..23.
- alarm_minutes  output  6  alarm minutes, 0..59.
- mode  output  2  0 = CLOCK, 1 = ADJUST, 2 = RING; 3 is never driven.
- sel  output  2  field selected in ADJUST: 0 = hours, 1 = minutes, 2 = alarm_hours, 3 = alarm_minutes.
- alarm_en  output  1  alarm armed.
- buzzer  output  1  high exactly while mode == RING.

## Operation
**Reset values:** every output is 0 (time 00:00:00, alarm 00:00, mode CLOCK, sel 0, alarm_en 0, buzzer 0). Ring counter is 0.

**Button priority:** if several pulses are high in one cycle, only the highest is acted on: btn_c > btn_u > btn_d > btn_r > btn_l. The others are discarded, not queued.

**CLOCK state**
- On tick_1hz, time advances one second. seconds wraps 59→0 and carries into minutes; minutes wraps 59→0 and carries into hours; hours wraps 23→0.
- btn_c: go to ADJUST with sel = 0. A tick in the same cycle is still applied.
- btn_u: toggle alarm_en.
- btn_d, btn_l, btn_r: ignored.
- Alarm trigger: go to RING when all of the following hold in one cycle:
  - alarm_en = 1;
  - no btn_c in that cycle;
  - a tick rolls seconds 59→0;
  - the post-increment hours:minutes equals alarm_hours:alarm_minutes.
- Setting the time equal to the alarm time does not trigger a ring until the next rollover match.

**ADJUST state**
- Time counting is frozen; tick_1hz is ignored.
- btn_r: sel = sel + 1 mod 4.
- btn_l: sel = sel − 1 mod 4.
- btn_u: increment the selected field with wrap (hours fields 23→0, minute fields 59→0). No carry into other fields.
- btn_d: decrement the selected field with wrap (0→23 or 0→59). No borrow.
- btn_c: go to CLOCK, clear seconds to 0, sel returns to 0.

**RING state**
- Time keeps counting exactly as in CLOCK. The ring counter increments on each tick.
- Any button pulse: go to CLOCK with the ring counter cleared. The press has no other effect; btn_u does not toggle alarm_en here.
- When the ring counter reaches RING_SECONDS: go to CLOCK with the counter cleared.
- alarm_en stays 1 after a ring ends.

**Reset mid-operation:** asserting reset in any state immediately returns every output to its reset value, asynchronously.

## Timing
- Latency: a button pulse or tick sampled at edge n updates the affected outputs at edge n. Outputs are stable from just after that edge.
- Transition latency: mode and buzzer change on the same edge as the triggering event. The RING entry edge is the edge on which seconds shows 0.
- Back-to-back pulses on consecutive cycles are each acted on; there is no internal lockout.
- Output constraints: no output ever shows an out-of-range value. mode == 2 if and only if buzzer == 1.

## Test plan
1. **Basic counting:** reset, then 3661 ticks in CLOCK → 01:01:01. From 23:59:59, one more tick → 00:00:00.
2. **Field editing:** btn_c, then btn_d on sel 0 → hours 23. btn_r, then btn_u ×61 → minutes 1. btn_l ×2 → sel 3. btn_c → mode 0 and seconds 0.
3. **Ring and dismiss:**
   - Set alarm 00:02, btn_u in CLOCK → alarm_en 1.
   - Run 120 ticks → mode 2 and buzzer 1 on the edge where the time reads 00:02:00.
   - btn_l → mode 0, buzzer 0, alarm_en still 1.
4. **Ring timeout:** same setup, no presses → buzzer drops after exactly 60 further ticks, at time 00:03:00.
5. **Simultaneous events:**
   - btn_c with btn_u in CLOCK → ADJUST entered, alarm_en unchanged.
   - btn_c with a tick that would match the alarm → mode 1, no ring, tick applied.
   - In ADJUST, ticks leave the time unchanged.
6. **Reset mid-operation:** assert reset during RING and during ADJUST with sel = 2 → all outputs 0 within the same cycle, without waiting for a clk edge.

Source files
------------

// File: rtl/alarm_mode_controller.sv
// Alarm clock control FSM: timekeeping, alarm setting/arming, field adjust and ring handling.
// All outputs are registered; press pulses are one clk wide and resolved by fixed priority.
module alarm_mode_controller #(
  parameter int RING_SECONDS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_c,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic [1:0] mode,
  output logic [1:0] sel,
  output logic       alarm_en,
  output logic       buzzer
);
  localparam logic [1:0] CLOCK  = 2'd0;
  localparam logic [1:0] ADJUST = 2'd1;
  localparam logic [1:0] RING   = 2'd2;
  localparam logic [5:0] RING_LIM = 6'(RING_SECONDS);

  logic [4:0] n_hours, n_alarm_hours, h_inc;
  logic [5:0] n_minutes, n_seconds, n_alarm_minutes, m_inc, s_inc;
  logic [1:0] n_mode, n_sel;
  logic       n_alarm_en, n_buzzer;
  logic [5:0] ring_cnt, n_ring_cnt, cnt_inc;
  logic       p_c, p_u, p_d, p_r, p_l, any_btn;
  logic       sec_wrap, min_wrap, alarm_hit;
  logic [5:0] step_src, step_max, step_v;

  // Only the highest-priority press of a cycle is acted on.
  assign p_c     = btn_c;
  assign p_u     = btn_u & ~btn_c;
  assign p_d     = btn_d & ~btn_c & ~btn_u;
  assign p_r     = btn_r & ~btn_c & ~btn_u & ~btn_d;
  assign p_l     = btn_l & ~btn_c & ~btn_u & ~btn_d & ~btn_r;
  assign any_btn = btn_c | btn_u | btn_d | btn_r | btn_l;

  assign sec_wrap = (seconds == 6'd59);
  assign min_wrap = (minutes == 6'd59);
  assign s_inc    = sec_wrap ? 6'd0 : seconds + 6'd1;
  assign m_inc    = sec_wrap ? (min_wrap ? 6'd0 : minutes + 6'd1) : minutes;
  assign h_inc    = (sec_wrap && min_wrap) ? ((hours == 5'd23) ? 5'd0 : hours + 5'd1) : hours;
  assign cnt_inc  = ring_cnt + 6'd1;

  assign alarm_hit = alarm_en & ~btn_c & tick_1hz & sec_wrap &
                     (m_inc == alarm_minutes) & (h_inc == alarm_hours);

  // Shared wrap-around up/down step for whichever field sel points at.
  assign step_src = (sel == 2'd0) ? {1'b0, hours} :
                    (sel == 2'd1) ? minutes :
                    (sel == 2'd2) ? {1'b0, alarm_hours} : alarm_minutes;
  assign step_max = sel[0] ? 6'd59 : 6'd23;
  assign step_v   = p_u ? ((step_src == step_max) ? 6'd0 : step_src + 6'd1)
                        : ((step_src == 6'd0) ? step_max : step_src - 6'd1);

  always_comb begin
    n_hours         = hours;
    n_minutes       = minutes;
    n_seconds       = seconds;
    n_alarm_hours   = alarm_hours;
    n_alarm_minutes = alarm_minutes;
    n_mode          = mode;
    n_sel           = sel;
    n_alarm_en      = alarm_en;
    n_ring_cnt      = ring_cnt;
    case (mode)
      CLOCK: begin
        if (tick_1hz) begin
          n_seconds = s_inc;
          n_minutes = m_inc;
          n_hours   = h_inc;
        end
        if (p_c) begin
          n_mode = ADJUST;
          n_sel  = 2'd0;
        end else if (p_u) begin
          n_alarm_en = ~alarm_en;
        end
        if (alarm_hit) begin
          n_mode     = RING;
          n_ring_cnt = 6'd0;
        end
      end
      ADJUST: begin
        if (p_c) begin
          n_mode    = CLOCK;
          n_sel     = 2'd0;
          n_seconds = 6'd0;
        end else if (p_r) begin
          n_sel = sel + 2'd1;
        end else if (p_l) begin
          n_sel = sel - 2'd1;
        end else if (p_u || p_d) begin
          case (sel)
            2'd0:    n_hours         = step_v[4:0];
            2'd1:    n_minutes       = step_v;
            2'd2:    n_alarm_hours   = step_v[4:0];
            default: n_alarm_minutes = step_v;
          endcase
        end
      end
      RING: begin
        if (tick_1hz) begin
          n_seconds  = s_inc;
          n_minutes  = m_inc;
          n_hours    = h_inc;
          n_ring_cnt = cnt_inc;
        end
        if (any_btn || (tick_1hz && cnt_inc == RING_LIM)) begin
          n_mode     = CLOCK;
          n_ring_cnt = 6'd0;
        end
      end
      default: n_mode = CLOCK;
    endcase
    n_buzzer = (n_mode == RING);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hours         <= '0;
      minutes       <= '0;
      seconds       <= '0;
      alarm_hours   <= '0;
      alarm_minutes <= '0;
      mode          <= CLOCK;
      sel           <= '0;
      alarm_en      <= 1'b0;
      buzzer        <= 1'b0;
      ring_cnt      <= '0;
    end else begin
      hours         <= n_hours;
      minutes       <= n_minutes;
      seconds       <= n_seconds;
      alarm_hours   <= n_alarm_hours;
      alarm_minutes <= n_alarm_minutes;
      mode          <= n_mode;
      sel           <= n_sel;
      alarm_en      <= n_alarm_en;
      buzzer        <= n_buzzer;
      ring_cnt      <= n_ring_cnt;
    end
  end
endmodule
